// File: rtl/exu_wbu_if.sv
// Writeback bus between execute-stage result channels and the writeback unit.
// Master drives the three result channels; slave (exu_wbu) drives the RF port and hazard/hold info.
interface exu_wbu_if #(
   parameter int XLEN    = 32,
   parameter int RFIDX_W = 5
);
   logic               i_rdwen0;
   logic [RFIDX_W-1:0] i_rdidx0;
   logic [XLEN-1:0]    i_rdwdata0;
   logic               i_rdwen1;
   logic [RFIDX_W-1:0] i_rdidx1;
   logic [XLEN-1:0]    i_rdwdata1;
   logic               i_rdwen2;
   logic [RFIDX_W-1:0] i_rdidx2;
   logic [XLEN-1:0]    i_rdwdata2;

   logic               o_rf_wen;
   logic [RFIDX_W-1:0] o_rf_widx;
   logic [XLEN-1:0]    o_rf_wdata;
   logic               o_pend_vld1;
   logic [RFIDX_W-1:0] o_pend_idx1;
   logic               o_pend_vld2;
   logic [RFIDX_W-1:0] o_pend_idx2;
   logic               o_mdu_hold;
   logic               o_lsu_hold;
   logic               o_ovf;

   modport master (
      output i_rdwen0, i_rdidx0, i_rdwdata0,
      output i_rdwen1, i_rdidx1, i_rdwdata1,
      output i_rdwen2, i_rdidx2, i_rdwdata2,
      input  o_rf_wen, o_rf_widx, o_rf_wdata,
      input  o_pend_vld1, o_pend_idx1, o_pend_vld2, o_pend_idx2,
      input  o_mdu_hold, o_lsu_hold, o_ovf
   );

   modport slave (
      input  i_rdwen0, i_rdidx0, i_rdwdata0,
      input  i_rdwen1, i_rdidx1, i_rdwdata1,
      input  i_rdwen2, i_rdidx2, i_rdwdata2,
      output o_rf_wen, o_rf_widx, o_rf_wdata,
      output o_pend_vld1, o_pend_idx1, o_pend_vld2, o_pend_idx2,
      output o_mdu_hold, o_lsu_hold, o_ovf
   );
endinterface

// File: rtl/exu_wbu.sv
// Writeback unit: merges ALU (ch0), MDU (ch1) and LSU (ch2) results onto one RF write port.
// Define WBU_BYPASS_EN to let ch1/ch2 arrivals reach the port in their arrival cycle.
module exu_wbu #(
   parameter int XLEN    = 32,
   parameter int RFIDX_W = 5
) (
   input  logic      i_clk,
   input  logic      i_rstn,
   exu_wbu_if.slave  wb
);

   // Index 0 of the per-buffer arrays is ch1 (MDU), index 1 is ch2 (LSU).
   logic               w_wen0;
   logic               w_in_wen  [2];
   logic [RFIDX_W-1:0] w_in_idx  [2];
   logic [XLEN-1:0]    w_in_data [2];
   logic               w_raw     [2];
   logic               w_arr     [2];
   logic               w_kill    [2];
   logic               w_load    [2];
   logic               w_ovf_evt [2];
   logic               w_drain   [2];
   logic               w_byp     [2];
   logic               w_rr_flip;

   logic               r_vld  [2];
   logic [RFIDX_W-1:0] r_idx  [2];
   logic [XLEN-1:0]    r_data [2];
   logic               r_rr;
   logic               r_ovf;

   logic               w_sel_wen;
   logic [RFIDX_W-1:0] w_sel_idx;
   logic [XLEN-1:0]    w_sel_data;

   assign w_wen0       = wb.i_rdwen0 && (wb.i_rdidx0 != '0);
   assign w_in_wen[0]  = wb.i_rdwen1;
   assign w_in_idx[0]  = wb.i_rdidx1;
   assign w_in_data[0] = wb.i_rdwdata1;
   assign w_in_wen[1]  = wb.i_rdwen2;
   assign w_in_idx[1]  = wb.i_rdidx2;
   assign w_in_data[1] = wb.i_rdwdata2;

   // ch0 is the youngest writer, so a matching ch0 write kills older arrivals; ch2 beats ch1 on a tie.
   assign w_arr[0] = w_raw[0]
                     && !(w_wen0 && (w_in_idx[0] == wb.i_rdidx0))
                     && !(w_raw[1] && (w_in_idx[0] == w_in_idx[1]));
   assign w_arr[1] = w_raw[1]
                     && !(w_wen0 && (w_in_idx[1] == wb.i_rdidx0));

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_buf
         assign w_raw[gi]     = w_in_wen[gi] && (w_in_idx[gi] != '0);
         assign w_kill[gi]    = w_wen0 && r_vld[gi] && (r_idx[gi] == wb.i_rdidx0);
         assign w_load[gi]    = w_arr[gi] && !w_byp[gi] && (!r_vld[gi] || w_drain[gi]);
         assign w_ovf_evt[gi] = w_arr[gi] && r_vld[gi] && !w_drain[gi];

         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               r_vld[gi]  <= 1'b0;
               r_idx[gi]  <= '0;
               r_data[gi] <= '0;
            end else if (w_load[gi]) begin
               r_vld[gi]  <= 1'b1;
               r_idx[gi]  <= w_in_idx[gi];
               r_data[gi] <= w_in_data[gi];
            end else if (w_drain[gi] || w_kill[gi]) begin
               r_vld[gi]  <= 1'b0;
            end
         end
      end
   endgenerate

   // Port arbitration: ch0, then buffered results (round robin when both wait), then bypass.
   always_comb begin
      w_drain[0] = 1'b0;
      w_drain[1] = 1'b0;
      w_byp[0]   = 1'b0;
      w_byp[1]   = 1'b0;
      w_rr_flip  = 1'b0;
      if (w_wen0) begin
         w_rr_flip = 1'b0;
      end else if (r_vld[0] && r_vld[1]) begin
         w_rr_flip = 1'b1;
         if (r_rr) begin
            w_drain[1] = 1'b1;
         end else begin
            w_drain[0] = 1'b1;
         end
      end else if (r_vld[0]) begin
         w_drain[0] = 1'b1;
      end else if (r_vld[1]) begin
         w_drain[1] = 1'b1;
`ifdef WBU_BYPASS_EN
      end else if (w_arr[0]) begin
         w_byp[0] = 1'b1;
      end else if (w_arr[1]) begin
         w_byp[1] = 1'b1;
`endif
      end
   end

   always_comb begin
      w_sel_wen  = 1'b0;
      w_sel_idx  = '0;
      w_sel_data = '0;
      if (w_wen0) begin
         w_sel_wen  = 1'b1;
         w_sel_idx  = wb.i_rdidx0;
         w_sel_data = wb.i_rdwdata0;
      end else if (w_drain[0]) begin
         w_sel_wen  = 1'b1;
         w_sel_idx  = r_idx[0];
         w_sel_data = r_data[0];
      end else if (w_drain[1]) begin
         w_sel_wen  = 1'b1;
         w_sel_idx  = r_idx[1];
         w_sel_data = r_data[1];
      end else if (w_byp[0]) begin
         w_sel_wen  = 1'b1;
         w_sel_idx  = w_in_idx[0];
         w_sel_data = w_in_data[0];
      end else if (w_byp[1]) begin
         w_sel_wen  = 1'b1;
         w_sel_idx  = w_in_idx[1];
         w_sel_data = w_in_data[1];
      end
   end

   // r_rr = 0 favours ch1 on the next two-way contention.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_rr  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         if (w_rr_flip) begin
            r_rr <= ~r_rr;
         end
         if (w_ovf_evt[0] || w_ovf_evt[1]) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign wb.o_rf_wen    = w_sel_wen;
   assign wb.o_rf_widx   = w_sel_idx;
   assign wb.o_rf_wdata  = w_sel_data;
   assign wb.o_pend_vld1 = r_vld[0];
   assign wb.o_pend_idx1 = r_vld[0] ? r_idx[0] : '0;
   assign wb.o_pend_vld2 = r_vld[1];
   assign wb.o_pend_idx2 = r_vld[1] ? r_idx[1] : '0;
   assign wb.o_mdu_hold  = r_vld[0];
   assign wb.o_lsu_hold  = r_vld[1];
   assign wb.o_ovf       = r_ovf;

endmodule

// File: tb/tb_exu_wbu.sv
// Directed scoreboard bench for exu_wbu: expected RF writes (cycle, idx, data) are queued by the
// stimulus and checked by a monitor on every o_rf_wen; hazard/hold/overflow outputs checked inline.
module tb_exu_wbu;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      int          c;
      logic [4:0]  idx;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];

   exu_wbu_if #(.XLEN(32), .RFIDX_W(5)) bus ();

   exu_wbu #(.XLEN(32), .RFIDX_W(5)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .wb     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push(input int c, input logic [4:0] idx, input logic [31:0] data);
      exp_t e;
      e.c    = c;
      e.idx  = idx;
      e.data = data;
      q.push_back(e);
   endfunction

   task automatic drive(input logic w0, input logic [4:0] x0, input logic [31:0] d0,
                        input logic w1, input logic [4:0] x1, input logic [31:0] d1,
                        input logic w2, input logic [4:0] x2, input logic [31:0] d2);
      bus.i_rdwen0 = w0; bus.i_rdidx0 = x0; bus.i_rdwdata0 = d0;
      bus.i_rdwen1 = w1; bus.i_rdidx1 = x1; bus.i_rdwdata1 = d1;
      bus.i_rdwen2 = w2; bus.i_rdidx2 = x2; bus.i_rdwdata2 = d2;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every RF write must be the next expected one, in the expected cycle.
   always @(negedge clk) begin
      if (bus.o_rf_wen === 1'b1) begin
         $display("rf write cyc=%0d x%0d=%08h", cyc, bus.o_rf_widx, bus.o_rf_wdata);
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL rfwrite: got cyc=%0d x%0d=%08h want no write", cyc, bus.o_rf_widx, bus.o_rf_wdata);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.c != cyc || e.idx !== bus.o_rf_widx || e.data !== bus.o_rf_wdata) begin
               bad++;
               $display("FAIL rfwrite: got cyc=%0d x%0d=%08h want cyc=%0d x%0d=%08h",
                        cyc, bus.o_rf_widx, bus.o_rf_wdata, e.c, e.idx, e.data);
            end
         end
      end
   end

   initial begin
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rf_wen", {31'b0, bus.o_rf_wen}, 0);
      chk("rst_pend_vld1", {31'b0, bus.o_pend_vld1}, 0);
      chk("rst_pend_vld2", {31'b0, bus.o_pend_vld2}, 0);
      chk("rst_pend_idx1", {27'b0, bus.o_pend_idx1}, 0);
      chk("rst_holds", {30'b0, bus.o_mdu_hold, bus.o_lsu_hold}, 0);
      chk("rst_ovf", {31'b0, bus.o_ovf}, 0);
      rstn = 1'b1;
      tick();

      // ch0 alone: same-cycle write.
      drive(1, 5, 32'h11, 0, 0, 0, 0, 0, 0);
      push(cyc, 5, 32'h11);
      @(negedge clk);
      chk("s1_pend_vld1", {31'b0, bus.o_pend_vld1}, 0);
      chk("s1_pend_vld2", {31'b0, bus.o_pend_vld2}, 0);
      tick();

      // ch0 and ch1 together: ch1 buffered, written next cycle.
      drive(1, 3, 32'hA, 1, 7, 32'hB, 0, 0, 0);
      push(cyc, 3, 32'hA);
      push(cyc + 1, 7, 32'hB);
      @(negedge clk);
      tick();
      idle();
      @(negedge clk);
      chk("s2_pend_vld1", {31'b0, bus.o_pend_vld1}, 1);
      chk("s2_pend_idx1", {27'b0, bus.o_pend_idx1}, 7);
      chk("s2_mdu_hold", {31'b0, bus.o_mdu_hold}, 1);
      tick();
      @(negedge clk);
      chk("s2_hold_clr", {31'b0, bus.o_mdu_hold}, 0);
      chk("s2_idx_clr", {27'b0, bus.o_pend_idx1}, 0);
      tick();

      // ch2 buffered, then killed by a younger ch0 write to the same index.
      drive(1, 1, 32'h1, 0, 0, 0, 1, 9, 32'h33);
      push(cyc, 1, 32'h1);
      @(negedge clk);
      tick();
      drive(1, 9, 32'h55, 0, 0, 0, 0, 0, 0);
      push(cyc, 9, 32'h55);
      @(negedge clk);
      chk("s3_lsu_hold", {31'b0, bus.o_lsu_hold}, 1);
      chk("s3_pend_idx2", {27'b0, bus.o_pend_idx2}, 9);
      tick();
      idle();
      @(negedge clk);
      chk("s3_lsu_hold_clr", {31'b0, bus.o_lsu_hold}, 0);
      tick();

      // Round robin: both buffers full twice; order alternates.
      drive(1, 1, 32'h2, 1, 4, 32'h44, 1, 6, 32'h66);
      push(cyc, 1, 32'h2);
      push(cyc + 1, 4, 32'h44);
      push(cyc + 2, 6, 32'h66);
      @(negedge clk);
      tick();
      idle();
      @(negedge clk);
      chk("s4_both_hold", {30'b0, bus.o_mdu_hold, bus.o_lsu_hold}, 3);
      tick();
      @(negedge clk);
      tick();
      drive(1, 1, 32'h3, 1, 4, 32'h45, 1, 6, 32'h67);
      push(cyc, 1, 32'h3);
      push(cyc + 1, 6, 32'h67);
      push(cyc + 2, 4, 32'h45);
      @(negedge clk);
      tick();
      idle();
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();

      // Overflow: ch1 arrives while buffer1 is full and ch0 owns the port.
      drive(1, 1, 32'h4, 1, 2, 32'h22, 0, 0, 0);
      push(cyc, 1, 32'h4);
      @(negedge clk);
      chk("s5_ovf_pre", {31'b0, bus.o_ovf}, 0);
      tick();
      drive(1, 3, 32'h5, 1, 8, 32'h88, 0, 0, 0);
      push(cyc, 3, 32'h5);
      push(cyc + 1, 2, 32'h22);
      @(negedge clk);
      chk("s5_ovf_same", {31'b0, bus.o_ovf}, 0);
      tick();
      idle();
      @(negedge clk);
      chk("s5_ovf_set", {31'b0, bus.o_ovf}, 1);
      chk("s5_kept_idx", {27'b0, bus.o_pend_idx1}, 2);
      tick();
      @(negedge clk);
      chk("s5_ovf_sticky", {31'b0, bus.o_ovf}, 1);
      chk("s5_buf_empty", {31'b0, bus.o_pend_vld1}, 0);
      tick();

      // ch1 alone on an idle port.
      drive(0, 0, 0, 1, 10, 32'h77, 0, 0, 0);
`ifdef WBU_BYPASS_EN
      push(cyc, 10, 32'h77);
`else
      push(cyc + 1, 10, 32'h77);
`endif
      @(negedge clk);
      chk("s6_pend_c0", {31'b0, bus.o_pend_vld1}, 0);
      tick();
      idle();
      @(negedge clk);
`ifdef WBU_BYPASS_EN
      chk("s6_pend_c1", {31'b0, bus.o_pend_vld1}, 0);
`else
      chk("s6_pend_c1", {31'b0, bus.o_pend_vld1}, 1);
`endif
      tick();
      @(negedge clk);
      chk("s6_pend_c2", {31'b0, bus.o_pend_vld1}, 0);
      tick();

      // Writes to x0 on every channel are ignored.
      drive(1, 0, 32'h99, 1, 0, 32'h98, 1, 0, 32'h97);
      @(negedge clk);
      chk("s7_x0_wen", {31'b0, bus.o_rf_wen}, 0);
      tick();
      idle();
      @(negedge clk);
      chk("s7_x0_pend", {30'b0, bus.o_pend_vld1, bus.o_pend_vld2}, 0);
      tick();

      // ch1 and ch2 together on an idle port: ch1 first.
      drive(0, 0, 0, 1, 11, 32'hA1, 1, 12, 32'hA2);
`ifdef WBU_BYPASS_EN
      push(cyc, 11, 32'hA1);
      push(cyc + 1, 12, 32'hA2);
`else
      push(cyc + 1, 11, 32'hA1);
      push(cyc + 2, 12, 32'hA2);
`endif
      @(negedge clk);
      tick();
      idle();
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();

      // Same-cycle WAW: ch1 arrival to the ch0 index is dropped.
      drive(1, 13, 32'hC0, 1, 13, 32'hC1, 0, 0, 0);
      push(cyc, 13, 32'hC0);
      @(negedge clk);
      tick();
      idle();
      @(negedge clk);
      chk("s9_waw_pend", {31'b0, bus.o_pend_vld1}, 0);
      tick();

      // Reset mid-operation flushes the buffered ch1 write.
      drive(1, 1, 32'h6, 1, 14, 32'hE0, 0, 0, 0);
      push(cyc, 1, 32'h6);
      @(negedge clk);
      tick();
      idle();
      #2 rstn = 1'b0;
      @(negedge clk);
      chk("s10_flush_pend", {31'b0, bus.o_pend_vld1}, 0);
      chk("s10_flush_ovf", {31'b0, bus.o_ovf}, 0);
      tick();
      rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         tick();
      end

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL leftover: got %0d writes outstanding want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exu_wbu.md
Name: exu_wbu

Overview:
- Writeback unit directly downstream of the execute stage.
- Merges three result channels onto the single register-file write port:
  - ch0: single-cycle ALU/BJU/SCU results
  - ch1: MDU results
  - ch2: LSU results
- ch1 and ch2 each have a one-entry pending buffer, so a long-latency result that loses the port is held, not lost.
- Exports pending-write hazard info and hold signals to issue logic.

Parameters:
- XLEN, 32, data width of results and register-file write data.
- RFIDX_W, 5, register index width.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_rdwen0 / i_rdidx0 / i_rdwdata0  in  1/RFIDX_W/XLEN  ch0 result
- i_rdwen1 / i_rdidx1 / i_rdwdata1  in  1/RFIDX_W/XLEN  ch1 (MDU) result
- i_rdwen2 / i_rdidx2 / i_rdwdata2  in  1/RFIDX_W/XLEN  ch2 (LSU) result
- o_rf_wen  out  1  register-file write enable
- o_rf_widx  out  RFIDX_W  register-file write index
- o_rf_wdata  out  XLEN  register-file write data
- o_pend_vld1 / o_pend_idx1  out  1/RFIDX_W  ch1 buffer holds a write (for RAW stall)
- o_pend_vld2 / o_pend_idx2  out  1/RFIDX_W  ch2 buffer holds a write (for RAW stall)
- o_mdu_hold  out  1  ch1 buffer full; issue must not dispatch an MDU op
- o_lsu_hold  out  1  ch2 buffer full; issue must not dispatch an LSU op
- o_ovf  out  1  sticky error: arrival on a channel whose buffer was already full

Behaviour:
- Reset is asynchronous on negedge i_rstn. Reset values:
  - both buffers invalid
  - round-robin pointer = ch1
  - o_ovf = 0
  - all outputs 0
- A write to index 0 on any channel is treated as no write (never buffered, never on the port).
- Register-file port (o_rf_*) is combinational from the current inputs and buffer state. Priority:
  1. ch0, if valid: written in the same cycle (latency 0).
  2. Otherwise, valid buffers. If both are valid, the round-robin pointer picks one; the pointer then toggles to the other channel.
  3. Otherwise (bypass), a new ch1 arrival, else a new ch2 arrival, is written in the same cycle.
- Arrival handling for ch1 and ch2, per cycle:
  - An arrival not written this cycle is loaded into its buffer at the clock edge.
  - If both ch1 and ch2 arrive with ch0 idle and both buffers empty: ch1 is written, ch2 is buffered.
  - A buffer that drains in cycle N may accept a new arrival at the same edge. That arrival is not written in cycle N.
- WAW kill (ch0 is always the younger instruction):
  - A ch0 write with idx equal to a valid buffer idx invalidates that buffer at the edge.
  - A ch0 write with idx equal to a same-cycle ch1/ch2 arrival idx drops that arrival.
  - The ch0 data is written; the older data is never written.
  - If ch1 and ch2 arrive with the same idx (not legal from the execute stage), ch2 wins and ch1 is dropped.
- Hold and pending outputs:
  - o_mdu_hold = buffer1 valid; o_lsu_hold = buffer2 valid.
  - o_pend_vld* / o_pend_idx* mirror the buffer contents. Idx reads 0 when the buffer is invalid.
- Overflow:
  - An arrival on ch1/ch2 while its buffer is valid and the buffer is not draining this cycle sets o_ovf.
  - o_ovf stays set until reset. The new arrival is discarded; the buffered entry is kept.
- Latency: ch0 is 0 cycles. ch1/ch2 are 0 when the port is free. Otherwise the worst case is 2 cycles with continuous ch0 writes absent, or unbounded while ch0 writes every cycle; issue logic sees the hold signals.
- Reset asserted mid-operation clears the buffers immediately. Buffered writes are lost, which is the intended flush semantics.

Optional Feature:
- Macro: WBU_BYPASS_EN.
- Defined: same-cycle bypass of ch1/ch2 arrivals to the port, as described above.
- Undefined: ch1/ch2 arrivals are always loaded into their buffer first.
  - Minimum latency becomes 1 cycle.
  - Port priority is ch0, then buffers only.
  - WAW kill and overflow rules are unchanged.
  - Removes the arrival-data mux from the port path for timing.

Test Plan:
- Reset, then ch0 wen idx=5 data=0x11 -> same cycle o_rf_wen=1, widx=5, wdata=0x11; no buffer valid.
- Same cycle: ch0 idx=3 data=0xA and ch1 idx=7 data=0xB -> cycle0 writes x3; o_pend_vld1=1, idx 7, o_mdu_hold=1; cycle1 (ch0 idle) writes x7=0xB; hold clears after cycle1.
- ch2 idx=9 buffered, then ch0 idx=9 data=0x55 -> x9=0x55 written, buffer2 invalidated, 0xB-class stale data never written.
- Both buffers valid (ch1 idx4, ch2 idx6), ch0 idle 2 cycles -> x4 then x6 written; repeat the scenario -> x6 then x4 (round robin).
- ch1 arrives idx 8 while buffer1 holds idx 2 and ch0 busy -> o_ovf=1 sticky; idx 2 still written later, idx 8 never written.
- Bypass check: ch1 idx 10 data 0x77 alone. WBU_BYPASS_EN defined -> written same cycle. Undefined -> written next cycle with o_pend_vld1=1 for one cycle.
